// File: rtl/muldiv_unit.sv
// Multi-cycle unsigned multiply/divide unit owning the architectural HI/LO
// registers. MULTU uses a shift-add product register, DIVU a restoring
// divider; both take WIDTH iterations. MFHI/MFLO read HI/LO combinationally.

package global_types;
    typedef enum logic [3:0] {
        ADDac, SUBac, ANDac, ORac, XORac, SLTac, SLLac, SRLac,
        MULTUac, DIVUac, MFHIac, MFLOac
    } alu_ctrl_t;
endpackage

module muldiv_unit
    import global_types::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  alu_ctrl_t        alu_ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] mf_out
);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    // acc: upper product half (MUL) or partial remainder (DIV)
    logic [WIDTH-1:0] acc_q, acc_d;
    // work: lower product half / multiplier (MUL) or dividend shifting into quotient (DIV)
    logic [WIDTH-1:0] work_q, work_d;
    // opnd: multiplicand (MUL) or divisor (DIV)
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;

    logic             md_op;
    logic             last_iter;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;

    // Per-iteration datapath: one add-and-shift step and one trial subtraction
    always_comb begin
        mul_sum   = {1'b0, acc_q} + (work_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {acc_q, work_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        last_iter = (count_q == WIDTH'(WIDTH - 1));
        md_op     = (alu_ctrl == MULTUac) || (alu_ctrl == DIVUac) ||
                    (alu_ctrl == MFHIac)  || (alu_ctrl == MFLOac);
    end

    // Next-state and datapath update for the IDLE/MUL/DIV controller
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        acc_d   = acc_q;
        work_d  = work_q;
        opnd_d  = opnd_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dbz_d   = dbz_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (en && (alu_ctrl == MULTUac || alu_ctrl == DIVUac)) begin
                    dbz_d   = 1'b0;
                    count_d = '0;
                    acc_d   = '0;
                    if (alu_ctrl == MULTUac) begin
                        state_d = MUL;
                        work_d  = b;
                        opnd_d  = a;
                    end else if (b == '0) begin
                        // Divide by zero resolves immediately without iterating
                        hi_d   = a;
                        lo_d   = '1;
                        dbz_d  = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        state_d = DIV;
                        work_d  = a;
                        opnd_d  = b;
                    end
                end
            end
            MUL: begin
                acc_d   = mul_sum[WIDTH:1];
                work_d  = {mul_sum[0], work_q[WIDTH-1:1]};
                count_d = count_q + 1'b1;
                if (last_iter) begin
                    hi_d    = acc_d;
                    lo_d    = work_d;
                    done_d  = 1'b1;
                    count_d = '0;
                    state_d = IDLE;
                end
            end
            DIV: begin
                // Non-negative trial difference means the quotient bit is 1
                if (!div_diff[WIDTH]) begin
                    acc_d  = div_diff[WIDTH-1:0];
                    work_d = {work_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d  = div_shift[WIDTH-1:0];
                    work_d = {work_q[WIDTH-2:0], 1'b0};
                end
                count_d = count_q + 1'b1;
                if (last_iter) begin
                    hi_d    = acc_d;
                    lo_d    = work_d;
                    done_d  = 1'b1;
                    count_d = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and register update; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            acc_q   <= '0;
            work_q  <= '0;
            opnd_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            acc_q   <= acc_d;
            work_q  <= work_d;
            opnd_q  <= opnd_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    // Outputs: status flags, stall request and move-from result
    always_comb begin
        busy        = (state_q != IDLE);
        stall       = busy & en & md_op;
        done        = done_q;
        div_by_zero = dbz_q;
        hi          = hi_q;
        lo          = lo_q;
        mf_out      = '0;
        if (alu_ctrl == MFHIac)      mf_out = hi_q;
        else if (alu_ctrl == MFLOac) mf_out = lo_q;
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed scenarios plus random instruction mix,
// scoreboard of expected HI/LO results checked cycle by cycle by a monitor.

module tb_muldiv_unit;
    import global_types::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    alu_ctrl_t    alu_ctrl = ADDac;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         stall, busy, done, div_by_zero;
    logic [W-1:0] hi, lo, mf_out;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .alu_ctrl(alu_ctrl), .a(a), .b(b),
        .stall(stall), .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .hi(hi), .lo(lo), .mf_out(mf_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           due;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] m_hi = '0, m_lo = '0;
    logic         m_dbz = 1'b0;
    int           busy_from = -10, busy_to = -20, clr_dbz_at = -1;
    bit           acc_flag = 1'b0;
    int           n_vec = 0, n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
        end
    endtask

    function automatic bit is_md(alu_ctrl_t op);
        return op inside {MULTUac, DIVUac, MFHIac, MFLOac};
    endfunction

    // Reference: plain arithmetic and the documented latencies
    function automatic exp_t ref_op(alu_ctrl_t op, logic [W-1:0] x, logic [W-1:0] y, int c);
        exp_t e;
        logic [2*W-1:0] p;
        e.dbz = 1'b0;
        if (op == MULTUac) begin
            p = (2*W)'(x) * (2*W)'(y);
            e.hi = p[2*W-1:W];
            e.lo = p[W-1:0];
            e.due = c + W + 1;
        end else if (y == '0) begin
            e.hi = x;
            e.lo = '1;
            e.dbz = 1'b1;
            e.due = c + 1;
        end else begin
            e.hi = x % y;
            e.lo = x / y;
            e.due = c + W + 1;
        end
        return e;
    endfunction

    // Monitor: compares DUT against the model every cycle, accepts issues
    exp_t         mon_e;
    logic         mon_eb, mon_ed;
    logic [W-1:0] mon_mf;
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            m_hi = '0; m_lo = '0; m_dbz = 1'b0;
            busy_from = -10; busy_to = -20; clr_dbz_at = -1;
        end else begin
            mon_eb = (cyc >= busy_from) && (cyc <= busy_to);
            mon_ed = 1'b0;
            if (cyc == clr_dbz_at) m_dbz = 1'b0;
            if (sb.size() > 0 && sb[0].due == cyc) begin
                mon_e = sb.pop_front();
                m_hi = mon_e.hi; m_lo = mon_e.lo; m_dbz = mon_e.dbz;
                mon_ed = 1'b1;
            end
            mon_mf = (alu_ctrl == MFHIac) ? m_hi : (alu_ctrl == MFLOac) ? m_lo : '0;
            chk("done", 64'(done), 64'(mon_ed));
            chk("busy", 64'(busy), 64'(mon_eb));
            chk("stall", 64'(stall), 64'(mon_eb & en & is_md(alu_ctrl)));
            chk("hi", 64'(hi), 64'(m_hi));
            chk("lo", 64'(lo), 64'(m_lo));
            chk("div_by_zero", 64'(div_by_zero), 64'(m_dbz));
            chk("mf_out", 64'(mf_out), 64'(mon_mf));
            if (!mon_eb && en && (alu_ctrl == MULTUac || alu_ctrl == DIVUac)) begin
                mon_e = ref_op(alu_ctrl, a, b, cyc);
                sb.push_back(mon_e);
                clr_dbz_at = cyc + 1;
                if (mon_e.due != cyc + 1) begin
                    busy_from = cyc + 1;
                    busy_to   = cyc + W;
                end
                acc_flag = 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(alu_ctrl_t op, logic [W-1:0] x, logic [W-1:0] y, logic e);
        en = e; alu_ctrl = op; a = x; b = y;
    endtask

    task automatic idle(int n);
        present(ADDac, '0, '0, 1'b0);
        repeat (n) step();
    endtask

    // Present a MULTU/DIVU until the model accepts it, then drop en
    task automatic issue(alu_ctrl_t op, logic [W-1:0] x, logic [W-1:0] y);
        acc_flag = 1'b0;
        present(op, x, y, 1'b1);
        for (int i = 0; i < 200; i++) begin
            step();
            if (acc_flag) begin
                present(ADDac, '0, '0, 1'b0);
                return;
            end
        end
        n_vec++; n_err++;
        $display("FAIL accept_timeout at cycle %0d: got no acceptance, expected within 200 cycles", cyc);
        present(ADDac, '0, '0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog at cycle %0d: got no finish, expected end of run", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        alu_ctrl_t    op;
        logic [W-1:0] x, y;
        int           mode;

        // Reset state
        repeat (2) step();
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_dbz", 64'(div_by_zero), 64'd0);
        rst_n = 1'b1;
        idle(2);

        // Full-scale multiply, small divide, divide by zero
        issue(MULTUac, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        idle(W + 2);
        issue(DIVUac, 32'd100, 32'd7);
        idle(W + 2);
        issue(DIVUac, 32'h1234, 32'd0);
        idle(3);

        // MFHI held from cycle 5 stalls until the product lands, then MFLO
        issue(MULTUac, 32'h8000_0000, 32'd4);
        idle(4);
        present(MFHIac, '0, '0, 1'b1);
        repeat (W - 4) step();
        present(MFLOac, '0, '0, 1'b1);
        step();
        idle(2);

        // Reset in the middle of a divide aborts it
        issue(DIVUac, 32'd1000, 32'd3);
        idle(9);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_hi", 64'(hi), 64'd0);
        chk("abort_lo", 64'(lo), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        step();
        rst_n = 1'b1;
        idle(1);
        issue(MULTUac, 32'd6, 32'd7);
        idle(W + 2);

        // MULTU presented during a DIVU waits for the finish cycle
        issue(DIVUac, 32'hDEAD_BEEF, 32'd13);
        idle(3);
        issue(MULTUac, 32'h0001_0003, 32'h0002_0005);
        idle(W + 2);

        // Random instruction mix
        for (int n = 0; n < 60; n++) begin
            op   = alu_ctrl_t'($urandom_range(0, 11));
            mode = $urandom_range(0, 5);
            x    = $urandom;
            y    = $urandom;
            if (mode == 0) y = '0;
            else if (mode == 1) begin x = $urandom_range(0, 255); y = $urandom_range(1, 15); end
            else if (mode == 2) begin x = '1; y = (y[0]) ? '1 : 32'd1; end
            if ((op == MULTUac || op == DIVUac) && ($urandom_range(0, 9) != 0))
                issue(op, x, y);
            else begin
                present(op, x, y, ($urandom_range(0, 9) != 0));
                repeat ($urandom_range(1, 6)) step();
            end
        end
        idle(W + 4);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
